// File: rtl/div_unit.sv
// div_unit: multi-cycle integer divider (DIV / DIVU / REM / REMU).
// Restoring radix-2 core, one quotient bit per cycle. Divide-by-zero and
// signed overflow are resolved at capture time and bypass the iteration.

module div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N);
  localparam logic [N-1:0] ONES   = {N{1'b1}};
  localparam logic [N-1:0] MIN_SV = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   dvd_q, dvd_d;     // dividend magnitude, quotient shifts in at LSB
  logic [N-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [N-1:0]   rem_q, rem_d;     // partial remainder
  logic           q_neg_q, q_neg_d; // negate quotient in FIX
  logic           r_neg_q, r_neg_d; // negate remainder in FIX
  logic           is_rem_q, is_rem_d;
  logic [N-1:0]   result_q, result_d;

  logic           accept_s;
  logic           signed_op_s;
  logic           b_zero_s;
  logic           ovf_s;
  logic [N-1:0]   mag_a_s;
  logic [N-1:0]   mag_b_s;
  logic [N:0]     rem_sh_s;
  logic [N:0]     diff_s;
  logic [N-1:0]   q_fix_s;
  logic [N-1:0]   r_fix_s;

  // Capture-time decode of the request on the input ports.
  assign signed_op_s = ~op[0];
  assign accept_s    = start && !flush && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign b_zero_s    = (B == '0);
  assign ovf_s       = signed_op_s && (A == MIN_SV) && (B == ONES);
  assign mag_a_s     = (signed_op_s && A[N-1]) ? -A : A;
  assign mag_b_s     = (signed_op_s && B[N-1]) ? -B : B;

  // One restoring step: shift in next dividend bit, trial-subtract the divisor.
  assign rem_sh_s = {rem_q, dvd_q[N-1]};
  assign diff_s   = rem_sh_s - {1'b0, dvs_q};

  // Sign correction applied to the finished magnitudes.
  assign q_fix_s = q_neg_q ? -dvd_q : dvd_q;
  assign r_fix_s = r_neg_q ? -rem_q : rem_q;

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

  // Next-state and datapath update for the divider FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    is_rem_d = is_rem_q;
    result_d = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          is_rem_d = op[1];
          q_neg_d  = signed_op_s && (A[N-1] != B[N-1]);
          r_neg_d  = signed_op_s && A[N-1];
          if (b_zero_s) begin
            result_d = op[1] ? A : ONES;
            state_d  = S_DONE;
          end else if (ovf_s) begin
            result_d = op[1] ? '0 : MIN_SV;
            state_d  = S_DONE;
          end else begin
            dvd_d   = mag_a_s;
            dvs_d   = mag_b_s;
            rem_d   = '0;
            cnt_d   = CW'(N - 1);
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (!diff_s[N]) begin
          rem_d = diff_s[N-1:0];
          dvd_d = {dvd_q[N-2:0], 1'b1};
        end else begin
          rem_d = rem_sh_s[N-1:0];
          dvd_d = {dvd_q[N-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = S_CALC;
        end
      end
      S_FIX: begin
        result_d = is_rem_q ? r_fix_s : q_fix_s;
        state_d  = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything: no result load, back to idle.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end else begin
      state_d  = state_d;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_rem_q <= is_rem_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: vector table, hand-written corner sequences and random ops
// checked against an arithmetic reference model.

module tb_div_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  int tests = 0;
  int fails = 0;

  div_unit #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          bsy;
  } vec_t;

  vec_t vecs[16];

  // Reference model: plain arithmetic with the special-case rules.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    if (!o[0]) return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit ref_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to its done pulse.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int exp_busy);
    int lat;
    int bcnt;
    logic [31:0] prev;
    bit early;
    prev  = result;
    early = 1'b0;
    op = o; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    A = $urandom; B = $urandom; op = 2'($urandom);
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      if (result !== prev) early = 1'b1;
      tick();
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, result, exp_res);
    check({name, " busy cycles"}, bcnt, exp_busy);
    check({name, " early result change"}, {31'd0, early}, 32'd0);
    tick();
    check({name, " done one cycle"}, {31'd0, done}, 32'd0);
  endtask

  // Count done pulses over a window of idle cycles.
  task automatic quiet_window(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) seen++;
      tick();
    end
    check({name, " no done"}, seen, 0);
  endtask

  initial begin
    int lat;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] prev;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         34, 33};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          34, 33};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 33};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 33};
    vecs[4]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0};
    vecs[5]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1,  0};
    vecs[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0};
    vecs[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0};
    vecs[8]  = '{2'b01, 32'h1234_5678,  32'd1,          32'h1234_5678,  34, 33};
    vecs[9]  = '{2'b00, 32'd0,          32'hFFFF_FFFD,  32'd0,          34, 33};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          34, 33};
    vecs[11] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, 33};
    vecs[12] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34, 33};
    vecs[13] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          34, 33};
    vecs[14] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34, 33};
    vecs[15] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  34, 33};

    // Reset state.
    tick();
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);

    // Release and issue on the very first edge with reset inactive.
    rst = 1'b1;
    run_op("first", 2'b01, 32'd100, 32'd7, 32'd14, 34, 33);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat, vecs[i].bsy);
    end

    // start held every cycle with changing operands; only the first completes.
    op = 2'b01; A = 32'd1000; B = 32'd10; start = 1'b1;
    tick();
    lat = 1;
    while (!done && lat < 200) begin
      A = $urandom; B = $urandom; op = 2'($urandom);
      tick();
      lat++;
    end
    check("hold-start latency", lat, 34);
    check("hold-start result", result, 32'd100);
    // Back-to-back request accepted from DONE.
    op = 2'b11; A = 32'd50; B = 32'd7;
    tick();
    start = 1'b0;
    check("b2b busy", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    check("b2b latency", lat, 34);
    check("b2b result", result, 32'd1);
    tick();

    // Flush at CALC cycle 10, with a simultaneous start.
    prev = result;
    op = 2'b01; A = 32'd999; B = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1; start = 1'b1; A = 32'd8; B = 32'd2;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush result held", result, prev);
    quiet_window("flush", 40);
    check("flush result still held", result, prev);
    run_op("after flush", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 33);

    // Asynchronous reset at CALC cycle 10.
    op = 2'b01; A = 32'd999; B = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    #1;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset result", result, 32'd0);
    tick();
    rst = 1'b1;
    quiet_window("midreset", 40);
    run_op("after reset", 2'b11, 32'd12345, 32'd100, 32'd45, 34, 33);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:       rb = -$urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb, ref_res(ro, ra, rb),
             ref_special(ro, ra, rb) ? 1 : 34, ref_special(ro, ra, rb) ? 0 : 33);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
